// File: rtl/emif_amm_mport_arbiter.sv
// Multi-port Avalon-MM front end for one EMIF user port.
// Round-robin arbitration across N_PORTS masters, write-burst locking,
// in-order read tag FIFO for steering read data back, calibration gating
// and sticky protocol error flags. Everything runs on emif_usr_clk.
module emif_amm_mport_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 576,
  parameter int BURST_W      = 7,
  parameter int TAG_DEPTH    = 16,
  parameter int MAX_RD_BEATS = 64
) (
  input  logic                            emif_usr_clk,
  input  logic                            emif_usr_reset,
  input  logic                            local_cal_success,
  input  logic                            local_cal_fail,
  input  logic [N_PORTS-1:0]              s_read,
  input  logic [N_PORTS-1:0]              s_write,
  input  logic [N_PORTS*ADDR_W-1:0]       s_address,
  input  logic [N_PORTS*DATA_W-1:0]       s_writedata,
  input  logic [N_PORTS*(DATA_W/8)-1:0]   s_byteenable,
  input  logic [N_PORTS*BURST_W-1:0]      s_burstcount,
  output logic [N_PORTS-1:0]              s_ready,
  output logic [DATA_W-1:0]               s_readdata,
  output logic [N_PORTS-1:0]              s_readdatavalid,
  input  logic                            amm_ready,
  output logic                            amm_read,
  output logic                            amm_write,
  output logic [ADDR_W-1:0]               amm_address,
  output logic [DATA_W-1:0]               amm_writedata,
  output logic [DATA_W/8-1:0]             amm_byteenable,
  output logic [BURST_W-1:0]              amm_burstcount,
  input  logic [DATA_W-1:0]               amm_readdata,
  input  logic                            amm_readdatavalid,
  output logic [$clog2(N_PORTS)-1:0]      grant_id,
  output logic [2:0]                      err_status
);

  localparam int PORT_W = $clog2(N_PORTS);
  localparam int BE_W   = DATA_W / 8;
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int OUT_W  = $clog2(MAX_RD_BEATS + 1);
  localparam int SUM_W  = ((OUT_W > BURST_W) ? OUT_W : BURST_W) + 1;

  localparam logic [SUM_W-1:0]  MAX_BEATS_L = SUM_W'(MAX_RD_BEATS);
  localparam logic [TAG_AW:0]   TAG_FULL_L  = (TAG_AW + 1)'(TAG_DEPTH);
  localparam logic [PORT_W-1:0] LAST_PORT_L = PORT_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    ST_WAIT_CAL,
    ST_RUN,
    ST_WBURST,
    ST_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]   grant_q, grant_d;
  logic [PORT_W-1:0]   lock_q, lock_d;
  logic [BURST_W-1:0]  burst_rem_q, burst_rem_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic [PORT_W-1:0]   tag_port_q [TAG_DEPTH];
  logic [PORT_W-1:0]   tag_port_d [TAG_DEPTH];
  logic [BURST_W-1:0]  tag_bc_q [TAG_DEPTH];
  logic [BURST_W-1:0]  tag_bc_d [TAG_DEPTH];
  logic [TAG_AW-1:0]   tag_wr_q, tag_wr_d;
  logic [TAG_AW-1:0]   tag_rd_q, tag_rd_d;
  logic [TAG_AW:0]     tag_cnt_q, tag_cnt_d;
  logic [BURST_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [2:0]          err_q, err_d;

  logic [ADDR_W-1:0]   p_addr  [N_PORTS];
  logic [DATA_W-1:0]   p_wdata [N_PORTS];
  logic [BE_W-1:0]     p_be    [N_PORTS];
  logic [BURST_W-1:0]  p_bc    [N_PORTS];
  logic [N_PORTS-1:0]  p_bc_zero;

  logic                tag_full;
  logic [SUM_W-1:0]    rd_sum;
  logic [N_PORTS-1:0]  rd_blocked;
  logic [N_PORTS-1:0]  cand;
  logic                any_cand;
  logic [PORT_W-1:0]   win;
  logic [PORT_W-1:0]   cidx;
  int                  idx;

  logic [PORT_W-1:0]   sel;
  logic                active;
  logic                accept;
  logic                push;
  logic                pop;
  logic                beat_sub;
  logic [BURST_W-1:0]  beat_next;

  assign tag_full   = (tag_cnt_q == TAG_FULL_L);
  assign s_readdata = amm_readdata;
  assign grant_id   = grant_q;
  assign err_status = err_q;

  // Split the packed per-port buses and map a zero burstcount to one beat
  always_comb begin
    p_bc_zero = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      p_addr[i]    = s_address[i*ADDR_W +: ADDR_W];
      p_wdata[i]   = s_writedata[i*DATA_W +: DATA_W];
      p_be[i]      = s_byteenable[i*BE_W +: BE_W];
      p_bc_zero[i] = (s_burstcount[i*BURST_W +: BURST_W] == '0);
      p_bc[i]      = p_bc_zero[i] ? BURST_W'(1) : s_burstcount[i*BURST_W +: BURST_W];
    end
  end

  // Candidate filtering by read limits, then round-robin search from the pointer
  always_comb begin
    rd_sum     = '0;
    rd_blocked = '0;
    cand       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      rd_sum        = SUM_W'(outstanding_q) + SUM_W'(p_bc[i]);
      rd_blocked[i] = tag_full || (rd_sum > MAX_BEATS_L);
      cand[i]       = s_write[i] | (s_read[i] & ~rd_blocked[i]);
    end
    any_cand = 1'b0;
    win      = '0;
    idx      = 0;
    cidx     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      cidx = PORT_W'(idx);
      if (!any_cand && cand[cidx]) begin
        any_cand = 1'b1;
        win      = cidx;
      end
    end
  end

  // Next-state, command path, read return steering and tag FIFO bookkeeping
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    lock_d          = lock_q;
    burst_rem_d     = burst_rem_q;
    outstanding_d   = outstanding_q;
    tag_port_d      = tag_port_q;
    tag_bc_d        = tag_bc_q;
    tag_wr_d        = tag_wr_q;
    tag_rd_d        = tag_rd_q;
    tag_cnt_d       = tag_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    err_d           = err_q;
    s_ready         = '0;
    s_readdatavalid = '0;
    amm_read        = 1'b0;
    amm_write       = 1'b0;
    active          = 1'b0;
    accept          = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    beat_sub        = 1'b0;
    beat_next       = beat_cnt_q + BURST_W'(1);

    sel            = (state_q == ST_WBURST) ? lock_q : win;
    amm_address    = p_addr[sel];
    amm_writedata  = p_wdata[sel];
    amm_byteenable = p_be[sel];
    amm_burstcount = p_bc[sel];

    if (!emif_usr_reset) begin
      case (state_q)
        ST_WAIT_CAL: begin
          if (local_cal_fail)         state_d = ST_FAIL;
          else if (local_cal_success) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!local_cal_success) begin
            state_d = ST_WAIT_CAL;
          end else begin
            active    = any_cand;
            amm_write = any_cand & s_write[win];
            amm_read  = any_cand & ~s_write[win];
            s_ready[win] = any_cand & amm_ready;
            accept    = any_cand & amm_ready;
            if (accept) begin
              rr_ptr_d = (win == LAST_PORT_L) ? '0 : win + PORT_W'(1);
              grant_d  = win;
              if (p_bc_zero[win]) err_d[1] = 1'b1;
              if (s_write[win]) begin
                if (p_bc[win] > BURST_W'(1)) begin
                  state_d     = ST_WBURST;
                  lock_d      = win;
                  burst_rem_d = p_bc[win] - BURST_W'(1);
                end
              end else begin
                push = 1'b1;
              end
            end
          end
        end
        ST_WBURST: begin
          active          = s_write[lock_q];
          amm_write       = active;
          s_ready[lock_q] = active & amm_ready;
          accept          = active & amm_ready;
          if (accept) begin
            burst_rem_d = burst_rem_q - BURST_W'(1);
            if (burst_rem_q == BURST_W'(1)) begin
              state_d = local_cal_success ? ST_RUN : ST_WAIT_CAL;
            end
          end
        end
        default: begin
          state_d = ST_FAIL;
        end
      endcase

      if (amm_readdatavalid) begin
        if (tag_cnt_q != '0) begin
          s_readdatavalid[tag_port_q[tag_rd_q]] = 1'b1;
          beat_sub = 1'b1;
          if (beat_next == tag_bc_q[tag_rd_q]) begin
            pop        = 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_next;
          end
        end else begin
          err_d[0] = 1'b1;
        end
      end
    end

    if (push) begin
      tag_port_d[tag_wr_q] = win;
      tag_bc_d[tag_wr_q]   = p_bc[win];
      tag_wr_d             = tag_wr_q + TAG_AW'(1);
      outstanding_d        = outstanding_d + OUT_W'(p_bc[win]);
    end
    if (pop) tag_rd_d = tag_rd_q + TAG_AW'(1);
    if (beat_sub) outstanding_d = outstanding_d - OUT_W'(1);
    tag_cnt_d = tag_cnt_q + (TAG_AW + 1)'(push) - (TAG_AW + 1)'(pop);

    if (state_d == ST_FAIL) err_d[2] = 1'b1;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) begin
      state_q       <= ST_WAIT_CAL;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      lock_q        <= '0;
      burst_rem_q   <= '0;
      outstanding_q <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      tag_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      lock_q        <= lock_d;
      burst_rem_q   <= burst_rem_d;
      outstanding_q <= outstanding_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_cnt_q     <= tag_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
    end
  end

  // Tag FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge emif_usr_clk) begin
    tag_port_q <= tag_port_d;
    tag_bc_q   <= tag_bc_d;
  end

endmodule

// File: tb/tb_emif_amm_mport_arbiter.sv
// Directed self-checking bench for emif_amm_mport_arbiter with hand-computed
// expectations for arbitration order, burst locking, read steering and limits.
module tb_emif_amm_mport_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 27;
  localparam int DW  = 576;
  localparam int BEW = DW / 8;
  localparam int BW  = 7;
  localparam int PW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cal_ok = 1'b0;
  logic              cal_fail = 1'b0;
  logic [NP-1:0]     s_read = '0;
  logic [NP-1:0]     s_write = '0;
  logic [NP*AW-1:0]  s_address = '0;
  logic [NP*DW-1:0]  s_writedata = '0;
  logic [NP*BEW-1:0] s_byteenable = '0;
  logic [NP*BW-1:0]  s_burstcount = '0;
  logic [NP-1:0]     s_ready;
  logic [DW-1:0]     s_readdata;
  logic [NP-1:0]     s_readdatavalid;
  logic              amm_ready = 1'b1;
  logic              amm_read;
  logic              amm_write;
  logic [AW-1:0]     amm_address;
  logic [DW-1:0]     amm_writedata;
  logic [BEW-1:0]    amm_byteenable;
  logic [BW-1:0]     amm_burstcount;
  logic [DW-1:0]     amm_readdata = '0;
  logic              amm_readdatavalid = 1'b0;
  logic [PW-1:0]     grant_id;
  logic [2:0]        err_status;

  int n_compared   = 0;
  int n_mismatched = 0;
  int beat_hits;
  int exp_order [5] = '{1, 2, 3, 0, 1};
  logic [63:0] exp_rdv [3] = '{64'h1, 64'h1, 64'h8};

  always #5 clk = ~clk;

  emif_amm_mport_arbiter dut (
    .emif_usr_clk      (clk),
    .emif_usr_reset    (rst),
    .local_cal_success (cal_ok),
    .local_cal_fail    (cal_fail),
    .s_read            (s_read),
    .s_write           (s_write),
    .s_address         (s_address),
    .s_writedata       (s_writedata),
    .s_byteenable      (s_byteenable),
    .s_burstcount      (s_burstcount),
    .s_ready           (s_ready),
    .s_readdata        (s_readdata),
    .s_readdatavalid   (s_readdatavalid),
    .amm_ready         (amm_ready),
    .amm_read          (amm_read),
    .amm_write         (amm_write),
    .amm_address       (amm_address),
    .amm_writedata     (amm_writedata),
    .amm_byteenable    (amm_byteenable),
    .amm_burstcount    (amm_burstcount),
    .amm_readdata      (amm_readdata),
    .amm_readdatavalid (amm_readdatavalid),
    .grant_id          (grant_id),
    .err_status        (err_status)
  );

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic clockCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] portAddr(input int p);
    return AW'(32'h0001_0000 + 32'(p) * 32'h100);
  endfunction

  function automatic logic [63:0] portData(input int p);
    return 64'hDA7A_0000_0000_0000 | 64'(p);
  endfunction

  // Drive one upstream port's request signals
  task automatic applyStimulus(input int p, input logic rd, input logic wr, input logic [BW-1:0] bc);
    s_read[p]                   = rd;
    s_write[p]                  = wr;
    s_address[p*AW +: AW]       = portAddr(p);
    s_writedata[p*DW +: DW]     = {9{portData(p)}};
    s_byteenable[p*BEW +: BEW]  = '1;
    s_burstcount[p*BW +: BW]    = bc;
  endtask

  task automatic clearPorts();
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 1'b0, BW'(1));
  endtask

  task automatic returnBeat(input logic [63:0] d);
    amm_readdatavalid = 1'b1;
    amm_readdata      = {9{d}};
  endtask

  initial begin
    clearPorts();
    rst = 1'b1;
    repeat (3) clockCycle();
    checkOutput("rst_s_ready", 64'(s_ready), 64'h0);
    checkOutput("rst_amm_read", 64'(amm_read), 64'h0);
    checkOutput("rst_amm_write", 64'(amm_write), 64'h0);
    checkOutput("rst_grant", 64'(grant_id), 64'h0);
    checkOutput("rst_err", 64'(err_status), 64'h0);
    checkOutput("rst_rdv", 64'(s_readdatavalid), 64'h0);
    rst = 1'b0;

    // Calibration gating then first read from port 0
    applyStimulus(0, 1'b1, 1'b0, BW'(1));
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("wait_cal_ready", 64'(s_ready), 64'h0);
      clockCycle();
    end
    cal_ok = 1'b1;
    #1;
    checkOutput("cal_edge_ready", 64'(s_ready), 64'h0);
    clockCycle();
    #1;
    checkOutput("first_rd_amm_read", 64'(amm_read), 64'h1);
    checkOutput("first_rd_addr", 64'(amm_address), 64'(portAddr(0)));
    checkOutput("first_rd_ready", 64'(s_ready), 64'h1);
    clockCycle();
    checkOutput("first_rd_grant", 64'(grant_id), 64'h0);
    applyStimulus(0, 1'b0, 1'b0, BW'(1));
    returnBeat(64'h0000_BEEF_0000_0001);
    #1;
    checkOutput("first_rd_rdv", 64'(s_readdatavalid), 64'h1);
    checkOutput("first_rd_data", s_readdata[63:0], 64'h0000_BEEF_0000_0001);
    clockCycle();
    amm_readdatavalid = 1'b0;

    // All four ports writing single beats: pointer sits at 1 after the read
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 1'b1, BW'(1));
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("rr_ready", 64'(s_ready), 64'h1 << exp_order[k]);
      checkOutput("rr_addr", 64'(amm_address), 64'(portAddr(exp_order[k])));
      checkOutput("rr_wdata", amm_writedata[63:0], portData(exp_order[k]));
      clockCycle();
      checkOutput("rr_grant", 64'(grant_id), 64'(exp_order[k]));
    end
    clearPorts();

    // Move pointer to 1, then port 1 burst of 4 with port 2 competing
    applyStimulus(0, 1'b0, 1'b1, BW'(1));
    #1;
    checkOutput("p0_single_ready", 64'(s_ready), 64'h1);
    clockCycle();
    clearPorts();
    applyStimulus(1, 1'b0, 1'b1, BW'(4));
    applyStimulus(2, 1'b0, 1'b1, BW'(1));
    #1;
    checkOutput("burst_first_ready", 64'(s_ready), 64'h2);
    checkOutput("burst_bc", 64'(amm_burstcount), 64'h4);
    clockCycle();
    amm_ready = 1'b0;
    #1;
    checkOutput("burst_stall_ready", 64'(s_ready), 64'h0);
    checkOutput("burst_stall_addr", 64'(amm_address), 64'(portAddr(1)));
    clockCycle();
    amm_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      checkOutput("burst_beat_ready", 64'(s_ready), 64'h2);
      clockCycle();
    end
    applyStimulus(1, 1'b0, 1'b0, BW'(1));
    #1;
    checkOutput("post_burst_ready", 64'(s_ready), 64'h4);
    clockCycle();
    checkOutput("post_burst_grant", 64'(grant_id), 64'h2);
    clearPorts();

    // Port 0 read burst 2, port 3 single read, three beats returned
    applyStimulus(0, 1'b1, 1'b0, BW'(2));
    #1;
    checkOutput("rd2_amm_read", 64'(amm_read), 64'h1);
    checkOutput("rd2_bc", 64'(amm_burstcount), 64'h2);
    clockCycle();
    clearPorts();
    applyStimulus(3, 1'b1, 1'b0, BW'(1));
    #1;
    checkOutput("rd3_ready", 64'(s_ready), 64'h8);
    clockCycle();
    clearPorts();
    for (int b = 0; b < 3; b++) begin
      returnBeat(64'hC0DE_0000_0000_0000 | 64'(b));
      #1;
      checkOutput("ret_rdv", 64'(s_readdatavalid), exp_rdv[b]);
      checkOutput("ret_data", s_readdata[63:0], 64'hC0DE_0000_0000_0000 | 64'(b));
      clockCycle();
    end
    returnBeat(64'h0BAD);
    #1;
    checkOutput("stray_rdv", 64'(s_readdatavalid), 64'h0);
    clockCycle();
    amm_readdatavalid = 1'b0;
    #1;
    checkOutput("stray_err", 64'(err_status), 64'h1);

    // Zero burstcount forwarded as one
    applyStimulus(2, 1'b0, 1'b1, BW'(0));
    #1;
    checkOutput("bc0_amm_bc", 64'(amm_burstcount), 64'h1);
    checkOutput("bc0_ready", 64'(s_ready), 64'h4);
    clockCycle();
    clearPorts();
    #1;
    checkOutput("bc0_err", 64'(err_status), 64'h3);

    // Calibration drop mid-burst: burst finishes, then traffic gated
    applyStimulus(0, 1'b0, 1'b1, BW'(2));
    #1;
    checkOutput("caldrop_first", 64'(s_ready), 64'h1);
    clockCycle();
    cal_ok = 1'b0;
    #1;
    checkOutput("caldrop_last_beat", 64'(s_ready), 64'h1);
    clockCycle();
    applyStimulus(0, 1'b0, 1'b1, BW'(1));
    #1;
    checkOutput("caldrop_gated", 64'(s_ready), 64'h0);
    cal_ok = 1'b1;
    clockCycle();
    #1;
    checkOutput("caldrop_resume", 64'(s_ready), 64'h1);
    clockCycle();
    clearPorts();

    // Tag FIFO depth: 16 reads accepted, 17th blocked until a beat returns
    applyStimulus(0, 1'b1, 1'b0, BW'(1));
    for (int i = 0; i < 16; i++) begin
      #1;
      checkOutput("fifo_fill_ready", 64'(s_ready), 64'h1);
      clockCycle();
    end
    #1;
    checkOutput("fifo_full_ready", 64'(s_ready), 64'h0);
    checkOutput("fifo_full_read", 64'(amm_read), 64'h0);
    returnBeat(64'h1111);
    #1;
    checkOutput("fifo_pop_ready", 64'(s_ready), 64'h0);
    checkOutput("fifo_pop_rdv", 64'(s_readdatavalid), 64'h1);
    clockCycle();
    amm_readdatavalid = 1'b0;
    #1;
    checkOutput("fifo_reopen_ready", 64'(s_ready), 64'h1);
    clockCycle();
    clearPorts();
    beat_hits = 0;
    for (int i = 0; i < 16; i++) begin
      returnBeat(64'h2222);
      #1;
      if (s_readdatavalid == 4'h1) beat_hits++;
      clockCycle();
    end
    amm_readdatavalid = 1'b0;
    checkOutput("fifo_drain_beats", 64'(beat_hits), 64'd16);

    // Outstanding beat limit: second 64-beat read waits for full drain
    applyStimulus(0, 1'b1, 1'b0, BW'(64));
    #1;
    checkOutput("max_first_ready", 64'(s_ready), 64'h1);
    clockCycle();
    clearPorts();
    applyStimulus(1, 1'b1, 1'b0, BW'(64));
    beat_hits = 0;
    for (int k = 0; k < 64; k++) begin
      returnBeat(64'h3333);
      #1;
      if (k == 0 || k == 63) checkOutput("max_block_ready", 64'(s_ready), 64'h0);
      if (s_readdatavalid == 4'h1) beat_hits++;
      clockCycle();
    end
    amm_readdatavalid = 1'b0;
    checkOutput("max_drain_beats", 64'(beat_hits), 64'd64);
    #1;
    checkOutput("max_second_ready", 64'(s_ready), 64'h2);
    checkOutput("max_second_bc", 64'(amm_burstcount), 64'd64);
    clockCycle();
    clearPorts();

    // Reset with reads outstanding, then calibration failure
    cal_ok = 1'b0;
    rst = 1'b1;
    repeat (2) clockCycle();
    rst = 1'b0;
    #1;
    checkOutput("midrst_grant", 64'(grant_id), 64'h0);
    checkOutput("midrst_err", 64'(err_status), 64'h0);
    cal_fail = 1'b1;
    clockCycle();
    cal_fail = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, BW'(1));
    cal_ok = 1'b1;
    #1;
    checkOutput("calfail_err", 64'(err_status), 64'h4);
    checkOutput("calfail_ready", 64'(s_ready), 64'h0);
    clockCycle();
    #1;
    checkOutput("calfail_ready2", 64'(s_ready), 64'h0);
    checkOutput("calfail_read", 64'(amm_read), 64'h0);
    rst = 1'b1;
    clockCycle();
    rst = 1'b0;
    cal_ok = 1'b0;
    clearPorts();
    #1;
    checkOutput("calfail_cleared", 64'(err_status), 64'h0);
    returnBeat(64'h4444);
    #1;
    checkOutput("dropped_rdv", 64'(s_readdatavalid), 64'h0);
    clockCycle();
    amm_readdatavalid = 1'b0;
    #1;
    checkOutput("dropped_err", 64'(err_status), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
